// File: rtl/store_merge_buffer_if.sv
// Bundle between the MEM stage, the store merge buffer and the data-memory write ports.
// The slave modport is the buffer's view; the master modport is the pipeline/memory side.
interface store_merge_buffer_if #(
  parameter int LANES  = 4,
  parameter int WPORTS = 2,
  parameter int DEPTH  = 8,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  logic [LANES-1:0]               st_we;
  logic [LANES*AW-1:0]            st_addr;
  logic [LANES*DW-1:0]            st_wdata;
  logic [LANES*AW-1:0]            ld_addr;
  logic                           stall;
  logic [WPORTS-1:0]              mem_we;
  logic [WPORTS*AW-1:0]           mem_addr;
  logic [WPORTS*DW-1:0]           mem_wdata;
  logic [LANES-1:0]               fwd_hit;
  logic [LANES*DW-1:0]            fwd_data;
  logic                           empty;
  logic [$clog2(DEPTH+1)-1:0]     count;

  modport slave (
    input  st_we, st_addr, st_wdata, ld_addr,
    output stall, mem_we, mem_addr, mem_wdata, fwd_hit, fwd_data, empty, count
  );

  modport master (
    output st_we, st_addr, st_wdata, ld_addr,
    input  stall, mem_we, mem_addr, mem_wdata, fwd_hit, fwd_data, empty, count
  );
endinterface

// File: rtl/store_merge_buffer.sv
// In-order store merge buffer: issues up to WPORTS stores per cycle, queues the rest
// in a circular FIFO (any DEPTH) and forwards buffered data to same-cycle loads.
module store_merge_buffer #(
  parameter int LANES  = 4,
  parameter int WPORTS = 2,
  parameter int DEPTH  = 8,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic clk,
  input  logic reset,
  store_merge_buffer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] ent_valid;
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];

  logic             stall;
  int               n_drain;
  int               n_enq;
  logic [WPORTS-1:0] port_vld;
  logic [AW-1:0]    port_addr [WPORTS];
  logic [DW-1:0]    port_data [WPORTS];
  logic [LANES-1:0] enq_en;
  logic [PW-1:0]    enq_idx [LANES];

  // Pointer sums never exceed 2*DEPTH-1, so one conditional subtract is enough.
  function automatic int wrap(input int v);
    return (v >= DEPTH) ? v - DEPTH : v;
  endfunction

  assign stall = (DEPTH - int'(count)) < LANES;

  always_comb begin
    int rank;
    int slot;
    rank    = 0;
    slot    = 0;
    n_drain = (int'(count) < WPORTS) ? int'(count) : WPORTS;
    n_enq   = 0;
    port_vld = '0;
    enq_en   = '0;
    for (int p = 0; p < WPORTS; p++) begin
      port_addr[p] = '0;
      port_data[p] = '0;
    end
    for (int l = 0; l < LANES; l++) enq_idx[l] = '0;

    for (int p = 0; p < WPORTS; p++) begin
      if (p < n_drain) begin
        slot         = wrap(int'(head) + p);
        port_vld[p]  = 1'b1;
        port_addr[p] = ent_addr[PW'(slot)];
        port_data[p] = ent_data[PW'(slot)];
      end
    end

    // New stores fill the ports left over after the buffer, then spill into the FIFO.
    for (int l = 0; l < LANES; l++) begin
      if (!stall && bus.st_we[l]) begin
        slot = n_drain + rank;
        if (slot < WPORTS) begin
          for (int p = 0; p < WPORTS; p++) begin
            if (p == slot) begin
              port_vld[p]  = 1'b1;
              port_addr[p] = bus.st_addr[l*AW +: AW];
              port_data[p] = bus.st_wdata[l*DW +: DW];
            end
          end
        end else begin
          enq_en[l]  = 1'b1;
          enq_idx[l] = PW'(wrap(int'(tail) + n_enq));
          n_enq      = n_enq + 1;
        end
        rank = rank + 1;
      end
    end
  end

  // The younger of two same-word writes wins; the older still retires.
  always_comb begin
    logic we;
    we            = 1'b0;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    for (int p = 0; p < WPORTS; p++) begin
      we = port_vld[p] & ~reset;
      for (int j = p + 1; j < WPORTS; j++) begin
        if (port_vld[j] && (port_addr[j][AW-1:2] == port_addr[p][AW-1:2])) we = 1'b0;
      end
      bus.mem_we[p]               = we;
      bus.mem_addr[p*AW +: AW]    = port_addr[p];
      bus.mem_wdata[p*DW +: DW]   = port_data[p];
    end
  end

  always_comb begin
    int slot;
    slot         = 0;
    bus.fwd_hit  = '0;
    bus.fwd_data = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot = wrap(int'(head) + k);
        if (ent_valid[PW'(slot)] &&
            (ent_addr[PW'(slot)][AW-1:2] == bus.ld_addr[l*AW+2 +: AW-2])) begin
          bus.fwd_hit[l]            = 1'b1;
          bus.fwd_data[l*DW +: DW]  = ent_data[PW'(slot)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      for (int p = 0; p < WPORTS; p++) begin
        if (p < n_drain) ent_valid[PW'(wrap(int'(head) + p))] <= 1'b0;
      end
      for (int l = 0; l < LANES; l++) begin
        if (enq_en[l]) begin
          ent_valid[enq_idx[l]] <= 1'b1;
          ent_addr[enq_idx[l]]  <= bus.st_addr[l*AW +: AW];
          ent_data[enq_idx[l]]  <= bus.st_wdata[l*DW +: DW];
        end
      end
      head  <= PW'(wrap(int'(head) + n_drain));
      tail  <= PW'(wrap(int'(tail) + n_enq));
      count <= CW'(int'(count) - n_drain + n_enq);
    end
  end

  assign bus.stall = stall;
  assign bus.count = count;
  assign bus.empty = (count == '0);
endmodule

// File: tb/tb_store_merge_buffer.sv
// Directed and random bench for store_merge_buffer against a queue-based store model.
module tb_store_merge_buffer;
  localparam int LANES  = 4;
  localparam int WPORTS = 2;
  localparam int DEPTH  = 8;
  localparam int AW     = 32;
  localparam int DW     = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_merge_buffer_if #(.LANES(LANES), .WPORTS(WPORTS), .DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  store_merge_buffer #(.LANES(LANES), .WPORTS(WPORTS), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  ent_t q[$];
  logic [LANES-1:0] swe;
  logic [AW-1:0]    sa [LANES];
  logic [DW-1:0]    sd [LANES];
  logic [AW-1:0]    la [LANES];
  logic             rst_in;

  logic [WPORTS-1:0]    last_we;
  logic [WPORTS*AW-1:0] last_maddr;
  logic [WPORTS*DW-1:0] last_mdata;
  logic [LANES-1:0]     last_hit;
  logic [LANES*DW-1:0]  last_fwd;
  logic                 last_stall;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    swe = '0;
    rst_in = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      sa[l] = '0;
      sd[l] = '0;
      la[l] = 32'h0000_F000 + 32'(l * 4);
    end
  endtask

  task automatic cycle();
    ent_t iss[$];
    ent_t newq[$];
    logic [WPORTS-1:0]   ewe;
    logic [LANES-1:0]    ehit;
    logic [LANES*DW-1:0] efwd;
    logic                es;
    int                  nd;
    @(negedge clk);
    reset     = rst_in;
    bus.st_we = swe;
    for (int l = 0; l < LANES; l++) begin
      bus.st_addr[l*AW +: AW]  = sa[l];
      bus.st_wdata[l*DW +: DW] = sd[l];
      bus.ld_addr[l*AW +: AW]  = la[l];
    end
    #2;
    last_we    = bus.mem_we;
    last_maddr = bus.mem_addr;
    last_mdata = bus.mem_wdata;
    last_hit   = bus.fwd_hit;
    last_fwd   = bus.fwd_data;
    last_stall = bus.stall;
    if (rst_in) begin
      chk("reset_cycle_mem_we", bus.mem_we, '0);
      q.delete();
    end else begin
      es = (DEPTH - q.size()) < LANES;
      for (int i = 0; i < q.size() && i < WPORTS; i++) iss.push_back(q[i]);
      nd = iss.size();
      if (!es) begin
        for (int l = 0; l < LANES; l++)
          if (swe[l]) newq.push_back('{a: sa[l], d: sd[l]});
      end
      while (iss.size() < WPORTS && newq.size() > 0) iss.push_back(newq.pop_front());
      ewe = '0;
      for (int p = 0; p < iss.size(); p++) begin
        ewe[p] = 1'b1;
        for (int j = p + 1; j < iss.size(); j++)
          if (iss[j].a[AW-1:2] == iss[p].a[AW-1:2]) ewe[p] = 1'b0;
      end
      ehit = '0;
      efwd = '0;
      for (int l = 0; l < LANES; l++) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].a[AW-1:2] == la[l][AW-1:2]) begin
            ehit[l] = 1'b1;
            efwd[l*DW +: DW] = q[i].d;
          end
        end
      end
      chk("stall", bus.stall, es);
      chk("count", bus.count, q.size());
      chk("empty", bus.empty, q.size() == 0);
      chk("mem_we", bus.mem_we, ewe);
      for (int p = 0; p < WPORTS; p++) begin
        if (ewe[p]) begin
          chk("mem_addr", bus.mem_addr[p*AW +: AW], iss[p].a);
          chk("mem_wdata", bus.mem_wdata[p*DW +: DW], iss[p].d);
        end
      end
      chk("fwd_hit", bus.fwd_hit, ehit);
      chk("fwd_data", bus.fwd_data, efwd);
      repeat (nd) void'(q.pop_front());
      foreach (newq[i]) q.push_back(newq[i]);
    end
    @(posedge clk);
  endtask

  task automatic group4(input logic [AW-1:0] base, input logic [DW-1:0] dbase);
    set_idle();
    swe = 4'b1111;
    for (int l = 0; l < LANES; l++) begin
      sa[l] = base + AW'(l * 4);
      sd[l] = dbase + DW'(l);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.st_we = '0;
    bus.st_addr = '0;
    bus.st_wdata = '0;
    bus.ld_addr = '0;
    set_idle();
    rst_in = 1'b1;
    cycle();
    set_idle();
    cycle();
    chk("post_reset_empty", bus.empty, 1'b1);
    chk("post_reset_stall", last_stall, 1'b0);

    // Two stores with an empty buffer issue with zero latency.
    set_idle();
    swe = 4'b0101;
    sa[0] = 32'h100; sd[0] = 32'hA;
    sa[2] = 32'h104; sd[2] = 32'hB;
    cycle();
    chk("t1_we", last_we, 2'b11);
    chk("t1_p0_addr", last_maddr[0 +: AW], 32'h100);
    chk("t1_p1_data", last_mdata[DW +: DW], 32'hB);
    #1 chk("t1_count", bus.count, 0);

    // Four stores: two issue now, two drain next cycle.
    group4(32'h10, 32'h1);
    cycle();
    #1 chk("t2_count", bus.count, 2);
    set_idle();
    cycle();
    chk("t2_p0_addr", last_maddr[0 +: AW], 32'h18);
    chk("t2_p1_addr", last_maddr[AW +: AW], 32'h1C);
    #1 chk("t2_empty", bus.empty, 1'b1);

    // Back-to-back full groups fill the FIFO until stall.
    group4(32'h1000, 32'h100); cycle(); #1 chk("t3_count_a", bus.count, 2);
    group4(32'h2000, 32'h200); cycle(); #1 chk("t3_count_b", bus.count, 4);
    group4(32'h3000, 32'h300); cycle(); #1 chk("t3_count_c", bus.count, 6);
    group4(32'h4000, 32'h400); cycle();
    chk("t3_stall", last_stall, 1'b1);
    #1 chk("t3_count_d", bus.count, 4);
    set_idle();
    repeat (4) cycle();

    // Same-word conflict: the younger lane wins.
    set_idle();
    swe = 4'b1010;
    sa[1] = 32'h200; sd[1] = 32'h11;
    sa[3] = 32'h200; sd[3] = 32'h22;
    cycle();
    chk("t4_we", last_we, 2'b10);
    chk("t4_p1_data", last_mdata[DW +: DW], 32'h22);

    // Forwarding returns the youngest buffered match.
    set_idle();
    swe = 4'b1111;
    sa[0] = 32'h500; sd[0] = 32'h1;
    sa[1] = 32'h504; sd[1] = 32'h2;
    sa[2] = 32'h300; sd[2] = 32'h5;
    sa[3] = 32'h300; sd[3] = 32'h9;
    cycle();
    set_idle();
    la[2] = 32'h302;
    cycle();
    chk("t5_hit", last_hit, 4'b0100);
    chk("t5_data", last_fwd, {32'h0, 32'h9, 32'h0, 32'h0});

    // Reset mid-operation discards buffered stores.
    set_idle();
    repeat (2) cycle();
    group4(32'h6000, 32'h60); cycle();
    group4(32'h7000, 32'h70); cycle();
    group4(32'h8000, 32'h80); swe = 4'b0111; cycle();
    #1 chk("t6_count5", bus.count, 5);
    set_idle();
    rst_in = 1'b1;
    cycle();
    set_idle();
    cycle();
    chk("t6_we", last_we, 2'b00);
    chk("t6_stall", last_stall, 1'b0);

    // Random traffic over a small word set to stress conflicts, wrap and forwarding.
    for (int n = 0; n < 400; n++) begin
      set_idle();
      rst_in = ($urandom_range(0, 59) == 0);
      swe = LANES'($urandom_range(0, 15));
      for (int l = 0; l < LANES; l++) begin
        sa[l] = AW'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
        sd[l] = $urandom;
        la[l] = AW'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
